// File: rtl/oric_tap_player.sv
// Oric fast-format tape transmitter: frames .TAP bytes (start, data LSB first, odd parity, stops) as pulse widths.
// Optional ORIC_TAP_REMOTE_EN adds the cassette relay input that gates and pauses playback.
module oric_tap_player #(
  parameter int CLKS_PER_US = 24,
  parameter int T_UNIT_US   = 208,
  parameter int STOP_BITS   = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        play,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
`ifdef ORIC_TAP_REMOTE_EN
  input  logic        remote,
`endif
  output logic        byte_ready,
  output logic        tape_out,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  localparam int T  = T_UNIT_US * CLKS_PER_US;
  localparam int CW = $clog2(2 * T + 1);
  localparam int NB = 10 + STOP_BITS;
  localparam int BW = $clog2(NB);
  localparam logic [CW-1:0] LEN1 = CW'(T);
  localparam logic [CW-1:0] LEN0 = CW'(2 * T);
  localparam logic [BW-1:0] LAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, PAUSE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [NB-1:0]   sr_q, sr_d;
  logic            tape_q, tape_d;
  logic            busy_q, busy_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic remote_ok;
  logic phase_end;
  logic last_end;
  logic accept;

`ifdef ORIC_TAP_REMOTE_EN
  assign remote_ok = remote;
`else
  assign remote_ok = 1'b1;
`endif

  assign phase_end  = (cnt_q == CW'(1));
  assign last_end   = (state_q == LOW) && (bit_q == LAST) && phase_end;
  assign byte_ready = play & remote_ok & ((state_q == IDLE) | last_end);
  assign accept     = byte_valid & byte_ready;

  assign frame_done = last_end;
  assign tape_out   = tape_q;
  assign busy       = busy_q;
  assign frame_cnt  = frame_cnt_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    sr_d        = sr_q;
    tape_d      = tape_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: ;
      HIGH: begin
        if (phase_end) begin
          state_d = LOW;
          cnt_d   = sr_q[0] ? LEN1 : LEN0;
          tape_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      LOW: begin
        if (phase_end) begin
          if (bit_q == LAST) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            state_d     = IDLE;
            busy_d      = 1'b0;
            tape_d      = 1'b0;
          end else begin
            sr_d  = sr_q >> 1;
            bit_d = bit_q + BW'(1);
            // Relay off at a cell boundary parks the player with the counter frozen.
            if (remote_ok) begin
              state_d = HIGH;
              cnt_d   = LEN1;
              tape_d  = 1'b1;
            end else begin
              state_d = PAUSE;
              tape_d  = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PAUSE: begin
        if (remote_ok) begin
          state_d = HIGH;
          cnt_d   = LEN1;
          tape_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A new byte can follow the last stop bit with no idle cycle in between.
    if (accept) begin
      state_d = HIGH;
      sr_d    = {{STOP_BITS{1'b1}}, ~^byte_data, byte_data, 1'b0};
      bit_d   = '0;
      cnt_d   = LEN1;
      tape_d  = 1'b1;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      sr_q        <= '0;
      tape_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      sr_q        <= sr_d;
      tape_q      <= tape_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_oric_tap_player.sv
// Directed bench for oric_tap_player with T = 4 clocks and 4 stop bits.
module tb_oric_tap_player;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        play = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
`ifdef ORIC_TAP_REMOTE_EN
  logic        remote = 1'b1;
`endif
  logic        byte_ready;
  logic        tape_out;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  oric_tap_player #(.CLKS_PER_US(1), .T_UNIT_US(4), .STOP_BITS(4)) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .play(play),
    .byte_valid(byte_valid),
    .byte_data(byte_data),
`ifdef ORIC_TAP_REMOTE_EN
    .remote(remote),
`endif
    .byte_ready(byte_ready),
    .tape_out(tape_out),
    .busy(busy),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;
  int runs[64];
  int nruns, flen, ndone, done_at;

  typedef struct {
    logic [7:0] dat;
    int         len;
    int         start_low;
    int         par_low;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Leaves the bench at posedge+1 of the first cycle of the accepted frame.
  task automatic wait_accept(input string name);
    int k = 0;
    @(negedge clk_sys);
    while (!(byte_ready && byte_valid) && k < 300) begin
      @(negedge clk_sys);
      k++;
    end
    if (k >= 300) chk({name, "_accept_timeout"}, 0, 1);
    @(posedge clk_sys);
    #1;
  endtask

  task automatic capture(input int drop_at, input int rem_lo_at, input int rem_hi_at);
    logic prev = 1'b0;
    logic t;
    nruns = 0; flen = 0; ndone = 0; done_at = -1;
    for (int i = 0; i < 64; i++) runs[i] = 0;
    while (busy && flen < 2000) begin
      t = tape_out;
      if (flen == 0 || t != prev) begin
        if (nruns < 64) runs[nruns] = 1;
        nruns++;
      end else if (nruns <= 64) begin
        runs[nruns-1]++;
      end
      prev = t;
      if (frame_done) begin
        ndone++;
        done_at = flen;
      end
      if (flen == drop_at) play = 1'b0;
`ifdef ORIC_TAP_REMOTE_EN
      if (flen == rem_lo_at) remote = 1'b0;
      if (flen == rem_hi_at) remote = 1'b1;
`endif
      flen++;
      @(posedge clk_sys);
      #1;
    end
    if (flen >= 2000) chk("frame_timeout", 0, 1);
  endtask

  initial begin
    int first_done;
    int k;

    vecs[0] = '{8'h00, 148, 8, 4};
    vecs[1] = '{8'hFF, 116, 8, 4};
    vecs[2] = '{8'h01, 148, 8, 8};
    vecs[3] = '{8'h80, 148, 8, 8};
    vecs[4] = '{8'h03, 140, 8, 4};

    play = 1'b1;
    #1;
    chk("rst_tape", tape_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_done", frame_done, 0);
    #22 reset_n = 1'b1;
    @(posedge clk_sys);
    #1;
    chk("rst_ready", byte_ready, 1);

    foreach (vecs[i]) begin
      byte_data  = vecs[i].dat;
      byte_valid = 1'b1;
      wait_accept("vec");
      byte_valid = 1'b0;
      chk("vec_first_high", tape_out, 1);
      capture(-1, -1, -1);
      exp_cnt++;
      chk("vec_len", flen, vecs[i].len);
      chk("vec_ndone", ndone, 1);
      chk("vec_done_at", done_at, vecs[i].len - 1);
      chk("vec_nruns", nruns, 28);
      chk("vec_high0", runs[0], 4);
      chk("vec_start_low", runs[1], vecs[i].start_low);
      chk("vec_par_low", runs[19], vecs[i].par_low);
      chk("vec_stop_low", runs[27], 4);
      chk("vec_cnt", frame_cnt, exp_cnt);
      chk("vec_idle_tape", tape_out, 0);
    end

    // Back-to-back 0x55 then 0xAA with byte_valid held high.
    byte_data  = 8'h55;
    byte_valid = 1'b1;
    wait_accept("b2b");
    byte_data = 8'hAA;
    k = 0;
    first_done = -1;
    while (first_done < 0 && k < 400) begin
      if (frame_done) begin
        first_done = k;
        chk("b2b_ready_at_done", byte_ready, 1);
      end
      k++;
      @(posedge clk_sys);
      #1;
    end
    chk("b2b_first_done", first_done, 131);
    byte_valid = 1'b0;
    chk("b2b_rise", tape_out, 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_cnt1", frame_cnt, exp_cnt + 1);
    capture(-1, -1, -1);
    exp_cnt += 2;
    chk("b2b_len2", flen, 132);
    chk("b2b_cnt2", frame_cnt, exp_cnt);

    // Play dropped mid-frame: the frame completes, then nothing more is accepted.
    byte_data  = 8'h00;
    byte_valid = 1'b1;
    wait_accept("drop");
    capture(20, -1, -1);
    exp_cnt++;
    chk("drop_len", flen, 148);
    chk("drop_ndone", ndone, 1);
    chk("drop_ready", byte_ready, 0);
    repeat (10) @(posedge clk_sys);
    #1;
    chk("drop_no_accept", busy, 0);
    chk("drop_cnt", frame_cnt, exp_cnt);
    byte_valid = 1'b0;
    play = 1'b1;

`ifdef ORIC_TAP_REMOTE_EN
    // Relay off at the end of the start cell for 50 clocks.
    byte_data  = 8'h00;
    byte_valid = 1'b1;
    wait_accept("remote");
    byte_valid = 1'b0;
    capture(-1, 11, 61);
    exp_cnt++;
    chk("remote_len_in_range", int'(flen >= 197 && flen <= 199), 1);
    chk("remote_ndone", ndone, 1);
    chk("remote_cnt", frame_cnt, exp_cnt);
`endif

    // Reset in the middle of a frame.
    byte_data  = 8'h00;
    byte_valid = 1'b1;
    wait_accept("midrst");
    byte_valid = 1'b0;
    repeat (30) @(posedge clk_sys);
    #1;
    chk("midrst_busy_before", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_tape", tape_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cnt", frame_cnt, 0);
    @(posedge clk_sys);
    #1;
    reset_n = 1'b1;
    #1;
    chk("midrst_ready", byte_ready, 1);
    @(posedge clk_sys);
    #1;
    chk("midrst_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
